// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce block.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_e;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned STABLE_CYCLES_DEF = 1000;
  localparam int unsigned CNT_W_DEF         = 16;
  localparam int unsigned LONG_CYCLES_DEF   = 50000;

  function automatic state_e idle_of(input logic lvl);
    return lvl ? IDLE_HIGH : IDLE_LOW;
  endfunction

endpackage

// File: rtl/debounce_if.sv
// Raw input, enable and conditioned outputs of the debouncer.
interface debounce_if;

  logic raw_in;
  logic enable;
  logic clean_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;
  logic long_press;

  modport master (
    output raw_in, enable,
    input  clean_out, rise_pulse, fall_pulse,
    input  busy, long_press
  );

  modport slave (
    input  raw_in, enable,
    output clean_out, rise_pulse, fall_pulse,
    output busy, long_press
  );

endinterface

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for one asynchronous input.
module sync_ff_chain #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// Debouncer with edge pulses; DEBOUNCE_LONG_PRESS_EN adds long_press.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter logic        RESET_LEVEL   = 1'b0,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF
) (
  input logic clock,
  input logic reset,
  debounce_if.slave bus
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1 ||
      (64'd1 << CNT_W) < 64'(STABLE_CYCLES)) begin : g_chk_cnt
    $error("CNT_W too small or STABLE_CYCLES < 1");
  end
  if (LONG_CYCLES < 1) begin : g_chk_long
    $error("LONG_CYCLES must be >= 1");
  end

  localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

  logic s;

  sync_ff_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk_i  (clock),
    .rst_ni (reset),
    .d_i    (bus.raw_in),
    .q_o    (s)
  );

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clean_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= idle_of(RESET_LEVEL);
      cnt_q   <= '0;
      clean_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (!bus.enable) begin
        state_q <= idle_of(clean_q);
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE_LOW: if (s) begin
            state_q <= CHK_HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
          CHK_HIGH: if (!s) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == TERM) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            clean_q <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
          IDLE_HIGH: if (!s) begin
            state_q <= CHK_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
          CHK_LOW: if (s) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == TERM) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.clean_out  = clean_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.busy       = busy_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LMAX = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LPRE = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] lcnt_q;
  logic          lp_q;
  logic          high_st;

  assign high_st = (state_q == IDLE_HIGH) ||
                   (state_q == CHK_LOW);

  // Saturating at LMAX limits it to one pulse per high period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lcnt_q <= '0;
      lp_q   <= 1'b0;
    end else begin
      lp_q <= 1'b0;
      if (bus.enable && high_st) begin
        if (lcnt_q != LMAX) begin
          lcnt_q <= lcnt_q + 1'b1;
          lp_q   <= (lcnt_q == LPRE);
        end
      end else begin
        lcnt_q <= '0;
      end
    end
  end

  assign bus.long_press = lp_q;
`else
  assign bus.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_pulse.sv
// Randomised plus directed bench for debounce_pulse against a streak model.
module tb_debounce_pulse;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int LONG   = 16;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  always #5 clock = ~clock;

  debounce_if bus();

  debounce_pulse #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .CNT_W         (4),
    .RESET_LEVEL   (1'b0),
    .LONG_CYCLES   (LONG)
  ) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int rise_n = 0, fall_n = 0, lp_n = 0;
  int last_rise = -1, last_fall = -1, last_lp = -1;
  logic busy_seen = 1'b0;

  logic m_clean, m_rise, m_fall, m_busy, m_lp;
  int   streak, hcnt;
  logic sq[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0d want %0d",
               nm, cyc, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Reference: clean_out flips once s has disagreed with it for
  // STABLE+1 consecutive enabled clocks; s is raw_in delayed SYNC clocks.
  initial begin
    logic s;
    logic pre;
    forever begin
      if (!rst_n) begin
        sq = {};
        repeat (SYNC) sq.push_back(1'b0);
        m_clean = 0; m_rise = 0; m_fall = 0;
        m_busy = 0; m_lp = 0;
        streak = 0; hcnt = 0;
      end else begin
        s = sq.pop_front();
        sq.push_back(bus.raw_in);
        pre = m_clean;
        m_rise = 0; m_fall = 0; m_lp = 0;
`ifdef DEBOUNCE_LONG_PRESS_EN
        if (bus.enable && pre) begin
          if (hcnt < LONG) begin
            hcnt++;
            m_lp = (hcnt == LONG);
          end
        end else begin
          hcnt = 0;
        end
`endif
        if (!bus.enable || s == m_clean) begin
          streak = 0;
        end else begin
          streak++;
          if (streak == STABLE + 1) begin
            m_clean = s;
            m_rise = s;
            m_fall = !s;
            streak = 0;
          end
        end
        m_busy = (streak != 0);
      end
      @(posedge clock or negedge rst_n);
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("clean_out", bus.clean_out, m_clean);
      chk("rise_pulse", bus.rise_pulse, m_rise);
      chk("fall_pulse", bus.fall_pulse, m_fall);
      chk("busy", bus.busy, m_busy);
      chk("long_press", bus.long_press, m_lp);
      if (bus.rise_pulse) begin rise_n++; last_rise = cyc; end
      if (bus.fall_pulse) begin fall_n++; last_fall = cyc; end
      if (bus.long_press) begin lp_n++; last_lp = cyc; end
      if (bus.busy) busy_seen = 1'b1;
    end
  end

  initial begin
    int c, r0, f0, l0, hold, en_hold;
    bus.raw_in = 1'b1;
    bus.enable = 1'b1;
    rst_n = 1'b0;

    // 1: reset with raw high, then release
    cycles(3);
    chk("t1_rst_clean", bus.clean_out, 0);
    chk("t1_rst_busy", bus.busy, 0);
    chk("t1_rst_rise", bus.rise_pulse, 0);
    rst_n = 1'b1;
    c = cyc;
    cycles(10);
    chk("t1_rise_n", rise_n, 1);
    chk("t1_rise_at", last_rise, c + 7);
    chk("t1_clean", bus.clean_out, 1);
    bus.raw_in = 1'b0;
    c = cyc;
    cycles(12);
    chk("t1_fall_n", fall_n, 1);
    chk("t1_fall_at", last_fall, c + 7);

    // 2: glitch
    r0 = rise_n;
    busy_seen = 1'b0;
    bus.raw_in = 1'b1;
    cycles(3);
    bus.raw_in = 1'b0;
    cycles(12);
    chk("t2_no_rise", rise_n, r0);
    chk("t2_busy_seen", busy_seen, 1);
    chk("t2_clean", bus.clean_out, 0);

    // 3: clean press and release
    r0 = rise_n;
    bus.raw_in = 1'b1;
    c = cyc;
    cycles(20);
    chk("t3_rise_n", rise_n, r0 + 1);
    chk("t3_rise_at", last_rise, c + 7);
    f0 = fall_n;
    bus.raw_in = 1'b0;
    c = cyc;
    cycles(12);
    chk("t3_fall_n", fall_n, f0 + 1);
    chk("t3_fall_at", last_fall, c + 7);

    // 4: bounce then hold high
    r0 = rise_n;
    c = 0;
    for (int i = 0; i < 10; i++) begin
      bus.raw_in = ((i / 2) % 2 == 0);
      if (i == 8) c = cyc;
      cycles(1);
    end
    cycles(20);
    chk("t4_rise_n", rise_n, r0 + 1);
    chk("t4_rise_at", last_rise, c + 7);
    bus.raw_in = 1'b0;
    cycles(12);

    // 5a: enable drop during CHK_HIGH
    bus.raw_in = 1'b1;
    cycles(4);
    chk("t5_busy_pre", bus.busy, 1);
    bus.enable = 1'b0;
    cycles(1);
    chk("t5_busy_off", bus.busy, 0);
    r0 = rise_n;
    cycles(10);
    chk("t5_no_rise", rise_n, r0);
    chk("t5_frozen", bus.clean_out, 0);
    bus.enable = 1'b1;
    cycles(12);
    chk("t5_requal", bus.clean_out, 1);
    bus.raw_in = 1'b0;
    cycles(12);

    // 5b: reset mid-qualification, no clock edge
    bus.raw_in = 1'b1;
    cycles(4);
    chk("t5_busy_pre2", bus.busy, 1);
    @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_clean", bus.clean_out, 0);
    chk("t5_rst_rise", bus.rise_pulse, 0);
    cycles(3);
    bus.raw_in = 1'b0;
    rst_n = 1'b1;
    cycles(8);

    // 6: long press
    r0 = rise_n;
    l0 = lp_n;
    bus.raw_in = 1'b1;
    c = cyc;
    cycles(40);
    chk("t6_rise_n", rise_n, r0 + 1);
`ifdef DEBOUNCE_LONG_PRESS_EN
    chk("t6_lp_n", lp_n, l0 + 1);
    chk("t6_lp_at", last_lp, c + 7 + LONG);
`else
    chk("t6_lp_off", lp_n, 0);
`endif
    bus.raw_in = 1'b0;
    cycles(12);

    // random phase
    hold = 0;
    en_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (hold == 0) begin
        bus.raw_in = ~bus.raw_in;
        hold = ($urandom_range(0, 9) == 0) ?
               $urandom_range(20, 40) :
               $urandom_range(1, 10);
      end else begin
        hold--;
      end
      if (en_hold == 0) begin
        bus.enable = ($urandom_range(0, 9) != 0);
        en_hold = $urandom_range(5, 60);
      end else begin
        en_hold--;
      end
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 799) == 0) begin
        #2 rst_n = 1'b0;
      end
    end
    rst_n = 1'b1;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
